// File: rtl/bmp_frame_ram_pkg.sv
// Shared types and default geometry for the BMP frame buffer.
// DEFINE-style macros are guarded so the same values can come from an external header.
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 20
`endif
`ifndef BMP_TOTAL_SIZE
`define BMP_TOTAL_SIZE 786486
`endif
`ifndef RAM_IDLE
`define RAM_IDLE 1'b0
`endif
`ifndef RAM_CLEAR
`define RAM_CLEAR 1'b1
`endif

package bmp_frame_ram_pkg;

    typedef enum logic {
        ST_IDLE  = `RAM_IDLE,
        ST_CLEAR = `RAM_CLEAR
    } ram_state_t;

    // Where the registered read result comes from: the array, or a held value
    // (bypassed write data, CLEAR_VALUE for out-of-range reads, or the reset value).
    typedef enum logic {
        SRC_HOLD = 1'b0,
        SRC_MEM  = 1'b1
    } rd_src_t;

endpackage

// File: rtl/bmp_ram_core.sv
// Plain synchronous single-write / single-read array, no reset on contents.
module bmp_ram_core #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bmp_frame_ram.sv
// Byte-addressable BMP frame buffer: registered read port, clear sweep,
// out-of-range detection and a saturating accepted-write counter.
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 20
`endif
`ifndef BMP_TOTAL_SIZE
`define BMP_TOTAL_SIZE 786486
`endif

module bmp_frame_ram
    import bmp_frame_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH  = `BYTE_WIDTH,
    parameter int                    DEPTH       = `BMP_TOTAL_SIZE,
    parameter int                    ADDR_WIDTH  = `ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_start,
    output logic                  busy,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_data_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  err_oob,
    input  logic                  err_clr
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    ram_state_t            state;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic                  wr_acc, rd_acc, wr_in, rd_in, bypass;
    logic                  core_we, core_re;
    logic [ADDR_WIDTH-1:0] core_waddr;
    logic [DATA_WIDTH-1:0] core_wdata, core_rdata;
    rd_src_t               rd_src_p1;
    logic [DATA_WIDTH-1:0] rd_hold_p1;

    assign busy     = (state == ST_CLEAR);
    assign wr_ready = !busy;
    assign rd_ready = !busy;

    assign wr_acc = wr_valid & wr_ready;
    assign rd_acc = rd_valid & rd_ready;
    assign wr_in  = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in  = ({1'b0, rd_addr} < DEPTH_L);
    assign bypass = wr_acc & wr_in & rd_in & (wr_addr == rd_addr);

    // The sweep owns the write port while busy; user writes are not accepted then.
    assign core_we    = busy | (wr_acc & wr_in);
    assign core_waddr = busy ? clr_ptr : wr_addr;
    assign core_wdata = busy ? CLEAR_VALUE : wr_data;
    assign core_re    = rd_acc & rd_in & !bypass;

    bmp_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .re    (core_re),
        .raddr (rd_addr),
        .rdata (core_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            clr_ptr  <= '0;
            wr_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_start) begin
                        state    <= ST_CLEAR;
                        clr_ptr  <= '0;
                        wr_count <= '0;
                    end else if (wr_acc && wr_in && wr_count != DEPTH_L) begin
                        wr_count <= wr_count + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clr_ptr == LAST_ADDR) begin
                        state <= ST_IDLE;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Error flag: a new out-of-range event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_oob <= 1'b0;
        end else if ((wr_acc && !wr_in) || (rd_acc && !rd_in)) begin
            err_oob <= 1'b1;
        end else if (err_clr) begin
            err_oob <= 1'b0;
        end
    end

    // ---- read stage p1: result selection registered alongside the array read ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_valid <= 1'b0;
            rd_src_p1     <= SRC_HOLD;
            rd_hold_p1    <= '0;
        end else begin
            rd_data_valid <= rd_acc;
            if (rd_acc) begin
                if (core_re) begin
                    rd_src_p1 <= SRC_MEM;
                end else begin
                    rd_src_p1  <= SRC_HOLD;
                    rd_hold_p1 <= bypass ? wr_data : CLEAR_VALUE;
                end
            end
        end
    end

    assign rd_data = (rd_src_p1 == SRC_MEM) ? core_rdata : rd_hold_p1;

endmodule

// File: tb/tb_bmp_frame_ram.sv
// Directed self-checking bench for bmp_frame_ram with DEPTH=16, ADDR_WIDTH=5.
module tb_bmp_frame_ram;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr_start;
    logic          busy;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_data_valid;
    logic [DW-1:0] rd_data;
    logic [AW:0]   wr_count;
    logic          err_oob;
    logic          err_clr;

    int checks = 0;
    int failures = 0;
    int n;

    bmp_frame_ram #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (AW),
        .CLEAR_VALUE (8'h00)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr_start     (clr_start),
        .busy          (busy),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .wr_count      (wr_count),
        .err_oob       (err_oob),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; return 1 ns after the edge so outputs have settled.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_valid = 1'b1; rd_addr = a;
        cyc();
        rd_valid = 1'b0;
        check({tag, "_vld"}, 32'(rd_data_valid), 32'd1);
        check({tag, "_dat"}, 32'(rd_data), 32'(exp));
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 64) begin
            cyc();
            cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; clr_start = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_addr = '0; err_clr = 1'b0;
        repeat (3) cyc();

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_rd_ready", 32'(rd_ready), 32'd1);
        check("rst_rd_vld", 32'(rd_data_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_err_oob", 32'(err_oob), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Full clear sweep: busy for exactly DEPTH cycles, then every cell reads 0.
        clr_start = 1'b1;
        cyc();
        clr_start = 1'b0;
        check("clr_wr_ready_low", 32'(wr_ready), 32'd0);
        check("clr_rd_ready_low", 32'(rd_ready), 32'd0);
        wait_idle(n);
        check("clr_busy_cycles", 32'(n), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            do_read($sformatf("clr_rd%0d", i), AW'(i), 8'h00);
        end

        // Write then read next cycle; data holds after the valid pulse.
        do_write(5'd3, 8'hA5);
        do_read("wr3_rd3", 5'd3, 8'hA5);
        check("wr_count_1", 32'(wr_count), 32'd1);
        cyc();
        check("rd_vld_pulse_drop", 32'(rd_data_valid), 32'd0);
        check("rd_data_hold", 32'(rd_data), 32'hA5);

        // Same-cycle write/read to address 7 returns the new data.
        wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 8'h5A;
        rd_valid = 1'b1; rd_addr = 5'd7;
        cyc();
        wr_valid = 1'b0; rd_valid = 1'b0;
        check("bypass_vld", 32'(rd_data_valid), 32'd1);
        check("bypass_dat", 32'(rd_data), 32'h5A);
        check("wr_count_2", 32'(wr_count), 32'd2);

        // Out-of-range handling.
        do_write(5'd0, 8'h11);
        do_write(5'd16, 8'hFF);
        check("oob_wr_err", 32'(err_oob), 32'd1);
        check("oob_wr_count", 32'(wr_count), 32'd3);
        do_read("oob_addr0", 5'd0, 8'h11);
        do_read("oob_rd20", 5'd20, 8'h00);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("err_clr", 32'(err_oob), 32'd0);
        err_clr = 1'b1; wr_valid = 1'b1; wr_addr = 5'd17; wr_data = 8'h99;
        cyc();
        err_clr = 1'b0; wr_valid = 1'b0;
        check("err_set_wins", 32'(err_oob), 32'd1);
        check("oob_wr_count2", 32'(wr_count), 32'd3);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        do_read("oob_rd_err", 5'd31, 8'h00);
        cyc();
        check("oob_rd_sets_err", 32'(err_oob), 32'd1);

        // Writes while busy are dropped.
        clr_start = 1'b1;
        cyc();
        clr_start = 1'b0;
        wr_valid = 1'b1; wr_addr = 5'd2; wr_data = 8'h77;
        check("busy_wr_ready", 32'(wr_ready), 32'd0);
        n = 0;
        while (busy && n < 64) begin
            cyc();
            n++;
        end
        wr_valid = 1'b0;
        check("busy_cycles2", 32'(n), 32'd16);
        check("busy_wr_count", 32'(wr_count), 32'd0);
        do_read("busy_wr_lost", 5'd2, 8'h00);

        // Reset mid-sweep leaves unreached cells intact.
        do_write(5'd10, 8'h33);
        clr_start = 1'b1;
        cyc();
        clr_start = 1'b0;
        repeat (4) cyc();
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        cyc();
        check("mid_rst_count", 32'(wr_count), 32'd0);
        do_read("mid_rst_addr10", 5'd10, 8'h33);

        // Counter saturation and reset by a following clear.
        for (int i = 0; i < 20; i++) begin
            do_write(AW'(i % 16), DW'(i + 8'h40));
            if (i == 14) check("count_15", 32'(wr_count), 32'd15);
        end
        check("count_sat", 32'(wr_count), 32'd16);
        do_read("sat_rewrite", 5'd3, 8'h53);
        clr_start = 1'b1; wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 8'hEE;
        cyc();
        clr_start = 1'b0; wr_valid = 1'b0;
        check("clr_same_cycle_busy", 32'(busy), 32'd1);
        wait_idle(n);
        check("clr_count_zero", 32'(wr_count), 32'd0);
        do_read("clr_addr5", 5'd5, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bmp_frame_ram.md
# bmp_frame_ram

Parametrised, byte-addressable frame buffer for BMP image data. It is the successor to the write-only BMP store: it adds a registered read port, a hardware clear sweep, out-of-range detection and an accepted-write counter. It sits between the BMP loader (writer) and downstream image-processing stages (readers), all on one clock.

## Interface

Parameters:
- `DATA_WIDTH`, default `` `BYTE_WIDTH `` (8). Width of one stored element.
- `DEPTH`, default `` `BMP_TOTAL_SIZE ``. Number of addressable elements.
- `ADDR_WIDTH`, default `` `ADDR_WIDTH ``. Address width. Must satisfy 2^ADDR_WIDTH ≥ DEPTH.
- `CLEAR_VALUE`, default 0. Value written by the clear sweep and returned on out-of-range reads.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `clr_start`  in  1  single-cycle request to start a clear sweep.
- `busy`  out  1  high while the clear sweep runs.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write accepted when `wr_valid & wr_ready`.
- `wr_addr`  in  ADDR_WIDTH  write address.
- `wr_data`  in  DATA_WIDTH  write data.
- `rd_valid`  in  1  read request.
- `rd_ready`  out  1  read accepted when `rd_valid & rd_ready`.
- `rd_addr`  in  ADDR_WIDTH  read address.
- `rd_data_valid`  out  1  one-cycle pulse; `rd_data` is valid.
- `rd_data`  out  DATA_WIDTH  read result; holds until the next accepted read.
- `wr_count`  out  ADDR_WIDTH+1  accepted in-range writes since the last clear; saturates at DEPTH.
- `err_oob`  out  1  sticky out-of-range flag.
- `err_clr`  in  1  clears `err_oob`.

## Operation

- FSM has two states, IDLE and CLEAR. Reset enters IDLE.
- IDLE → CLEAR when `clr_start` = 1.
  - `clr_ptr` is set to 0 and `wr_count` is set to 0.
- CLEAR writes CLEAR_VALUE to `mem[clr_ptr]` each cycle and increments `clr_ptr`.
  - After writing DEPTH-1, the FSM returns to IDLE.
  - `clr_start` is ignored while in CLEAR.
- `busy` = (state == CLEAR). `wr_ready` = `rd_ready` = !busy. Requests made while busy are dropped, not queued.
- Accepted write with `wr_addr` < DEPTH:
  - `mem[wr_addr]` ← `wr_data`.
  - `wr_count` increments, saturating at DEPTH. Rewrites of the same address count again.
- Accepted write with `wr_addr` ≥ DEPTH: memory is untouched, `wr_count` is unchanged, and `err_oob` is set.
- Accepted read with `rd_addr` < DEPTH returns `mem[rd_addr]`.
- Accepted read with `rd_addr` ≥ DEPTH returns CLEAR_VALUE, still pulses `rd_data_valid`, and sets `err_oob`.
- Read and write to the same in-range address in the same cycle: the read returns `wr_data` (write-first bypass).
- `err_oob` is sticky until `err_clr`. If a new out-of-range event and `err_clr` occur in the same cycle, the set wins.
- The memory array has no reset. Contents after `rst_n` are undefined until a clear sweep completes.

## Timing

- Reset values: `busy` 0, `wr_ready` 1, `rd_ready` 1, `rd_data_valid` 0, `rd_data` 0, `wr_count` 0, `err_oob` 0.
- Write latency: a value written in cycle N is visible to a read accepted in cycle N (via bypass) or any later cycle.
- Read latency is 1: a read accepted in cycle N gives `rd_data` and `rd_data_valid` in cycle N+1.
- Clear duration: `busy` goes high the cycle after `clr_start` and stays high exactly DEPTH cycles.
  - `wr_ready` and `rd_ready` fall in the same cycle `busy` rises.
- `clr_start` together with `wr_valid` or `rd_valid` in IDLE: that write and read are accepted in that cycle; the clear begins next cycle.
- `wr_count` after a clear: 0. Writes accepted in the same cycle as `clr_start` do not count.
- `err_oob` updates the cycle after the offending request.
- `rst_n` asserted mid-clear: immediate return to IDLE with `busy` = 0. Cells the sweep has not yet reached keep their prior contents.

## Structure

- DEFINE.vh supplies `` `BYTE_WIDTH ``, `` `ADDR_WIDTH `` and `` `BMP_TOTAL_SIZE `` as parameter defaults. Add state encodings `` `RAM_IDLE `` and `` `RAM_CLEAR `` there.
- One natural sub-module: `bmp_ram_core`, a plain synchronous single-write/single-read array with no reset.
  - The top level muxes the clear sweep onto its write port and holds the FSM, bypass, error and counter logic.

## Test plan

1. Reset, then `clr_start` with DEPTH=16 → `busy` high exactly 16 cycles; reads of addresses 0..15 each return 0x00 one cycle after request.
2. Write 0xA5 to address 3, then read address 3 the next cycle → `rd_data` = 0xA5 with `rd_data_valid` pulsed one cycle after the read; `wr_count` = 1.
3. Same-cycle write of 0x5A and read of address 7 → next cycle `rd_data` = 0x5A.
4. DEPTH=16: write to address 16 → `err_oob` = 1, `wr_count` unchanged, address 0 unchanged. Read address 20 → `rd_data` = 0x00 with valid. Pulse `err_clr` → `err_oob` = 0. Pulse `err_clr` together with a new out-of-range write → `err_oob` stays 1.
5. Start a clear; drive `wr_valid` while busy → `wr_ready` = 0 and the write is lost. Pre-write 0x33 to address 10, then assert `rst_n` low during sweep cycle 5 → `busy` = 0 immediately and address 10 still reads 0x33.
6. Perform 20 in-range writes with DEPTH=16 → `wr_count` saturates at 16. A following clear resets it to 0.
